// File: rtl/pe_ctrl_pkg.sv
// rtl/pe_ctrl_pkg.sv - shared state encoding and default parameters for the PE array controller
package pe_ctrl_pkg;

   localparam int DEF_ELEMENT_BITS = 8;
   localparam int DEF_P            = 4;
   localparam int DEF_CLK_RATIO    = 5;
   localparam int DEF_MAX_LEN      = 64;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      STREAM,
      DRAIN,
      DONE
   } pe_state_t;

endpackage

// File: rtl/pe_tick_gen.sv
// rtl/pe_tick_gen.sv - PE step prescaler; tick on the last count, hold freezes it there
module pe_tick_gen #(
   parameter int CLK_RATIO = 5
)(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_run,
   input  logic i_hold,
   input  logic i_clear,
   output logic o_tick
);

   localparam int CW = (CLK_RATIO > 1) ? $clog2(CLK_RATIO) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_RATIO - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_run && !i_hold) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_tick = i_run && (r_cnt == LAST);

endmodule

// File: rtl/pe_array_ctrl.sv
// rtl/pe_array_ctrl.sv - weight-load / stream / drain sequencer for a P-column PE array
// Optional PE_CTRL_STALL_CNT_EN adds o_stall_cnt (stalled STREAM cycles, saturating).
module pe_array_ctrl
   import pe_ctrl_pkg::*;
#(
   parameter int ELEMENT_BITS = DEF_ELEMENT_BITS,
   parameter int P            = DEF_P,
   parameter int CLK_RATIO    = DEF_CLK_RATIO,
   parameter int MAX_LEN      = DEF_MAX_LEN
)(
   input  logic                         i_sys_clk,
   input  logic                         i_reset_n,
   input  logic                         i_start,
   input  logic [$clog2(MAX_LEN+1)-1:0] i_vec_len,
   input  logic                         i_in_valid,
   input  logic [ELEMENT_BITS-1:0]      i_in_data,
   output logic                         o_in_ready,
   output logic                         o_pe_en,
   output logic                         o_w_load,
   output logic [$clog2(P)-1:0]         o_w_addr,
   output logic [ELEMENT_BITS-1:0]      o_pe_in_data,
   output logic                         o_out_valid,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_err
`ifdef PE_CTRL_STALL_CNT_EN
   ,
   output logic [15:0]                  o_stall_cnt
`endif
);

   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int AW = $clog2(P);

   pe_state_t               r_state, w_state_nxt;
   logic [LW-1:0]           r_len, r_step;
   logic [AW-1:0]           r_waddr;
   logic [ELEMENT_BITS-1:0] r_data;
   logic                    r_err;
   logic                    w_tick, w_idle, w_len_ok, w_accept, w_hold;

   assign w_idle   = (r_state == IDLE);
   assign w_len_ok = (int'(i_vec_len) >= P) && (int'(i_vec_len) <= MAX_LEN);
   assign w_accept = w_idle && i_start && w_len_ok;
   assign w_hold   = (r_state == STREAM) && w_tick && !i_in_valid;

   pe_tick_gen #(.CLK_RATIO(CLK_RATIO)) u_tick (
      .i_clk   (i_sys_clk),
      .i_rst_n (i_reset_n),
      .i_run   (!w_idle),
      .i_hold  (w_hold),
      .i_clear (w_idle),
      .o_tick  (w_tick)
   );

   always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      o_pe_en     = 1'b0;
      o_w_load    = 1'b0;
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) w_state_nxt = LOAD_W;
         end
         LOAD_W: begin
            o_w_load = 1'b1;
            o_pe_en  = w_tick;
            if (w_tick && r_waddr == AW'(P - 1)) w_state_nxt = STREAM;
         end
         STREAM: begin
            o_in_ready  = w_tick;
            o_pe_en     = w_tick && i_in_valid;
            // the first P-1 elements only fill the pipeline
            o_out_valid = o_pe_en && (r_step >= LW'(P - 1));
            if (o_pe_en && r_step == r_len - 1'b1) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            o_pe_en     = w_tick;
            o_out_valid = w_tick;
            if (w_tick && r_step == LW'(P - 2)) w_state_nxt = DONE;
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_len   <= '0;
         r_step  <= '0;
         r_waddr <= '0;
         r_data  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= w_idle && i_start && !w_len_ok;
         if (w_accept) begin
            r_len   <= i_vec_len;
            r_step  <= '0;
            r_waddr <= '0;
            r_data  <= '0;
         end else begin
            case (r_state)
               LOAD_W: if (w_tick) r_waddr <= (r_waddr == AW'(P - 1)) ? '0 : r_waddr + 1'b1;
               STREAM: if (o_pe_en) begin
                  r_data <= i_in_data;
                  r_step <= (r_step == r_len - 1'b1) ? '0 : r_step + 1'b1;
               end
               DRAIN: if (w_tick) begin
                  r_data <= '0;
                  r_step <= r_step + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef PE_CTRL_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
      if (!i_reset_n)                            r_stall_cnt <= '0;
      else if (w_accept)                         r_stall_cnt <= '0;
      else if (w_hold && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 1'b1;
   end

   assign o_stall_cnt = r_stall_cnt;
`endif

   assign o_w_addr     = r_waddr;
   assign o_pe_in_data = r_data;
   assign o_busy       = !w_idle;
   assign o_done       = (r_state == DONE);
   assign o_err        = r_err;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb/tb_pe_array_ctrl.sv - table-driven check of pe_array_ctrl job sequencing, stalls and reset
module tb_pe_array_ctrl;

   localparam int EB = 8;
   localparam int P  = 4;
   localparam int R  = 5;
   localparam int ML = 64;
   localparam int LW = $clog2(ML + 1);
   localparam int AW = $clog2(P);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] vec_len = '0;
   logic          in_valid = 1'b0;
   logic [EB-1:0] in_data = '0;
   logic          o_in_ready, o_pe_en, o_w_load, o_out_valid, o_busy, o_done, o_err;
   logic [AW-1:0] o_w_addr;
   logic [EB-1:0] o_pe_in_data;
`ifdef PE_CTRL_STALL_CNT_EN
   logic [15:0]   o_stall_cnt;
`endif

   int checks = 0;
   int failures = 0;

   pe_array_ctrl #(.ELEMENT_BITS(EB), .P(P), .CLK_RATIO(R), .MAX_LEN(ML)) dut (
      .i_sys_clk    (clk),
      .i_reset_n    (rst_n),
      .i_start      (start),
      .i_vec_len    (vec_len),
      .i_in_valid   (in_valid),
      .i_in_data    (in_data),
      .o_in_ready   (o_in_ready),
      .o_pe_en      (o_pe_en),
      .o_w_load     (o_w_load),
      .o_w_addr     (o_w_addr),
      .o_pe_in_data (o_pe_in_data),
      .o_out_valid  (o_out_valid),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_err        (o_err)
`ifdef PE_CTRL_STALL_CNT_EN
      ,
      .o_stall_cnt  (o_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int len;
      int hold_start;
      int stall_at;
      int stall_len;
      int exp_err;
      int exp_load;
      int exp_stream;
      int exp_drain;
      int exp_ov;
      int exp_done;
      int exp_stall;
   } vec_t;

   vec_t vecs[8];

   function automatic vec_t mk(int len, int hs, int sa, int sl, int e, int ld, int st,
                               int dr, int ov, int dn, int sc);
      vec_t v;
      v.len = len; v.hold_start = hs; v.stall_at = sa; v.stall_len = sl;
      v.exp_err = e; v.exp_load = ld; v.exp_stream = st; v.exp_drain = dr;
      v.exp_ov = ov; v.exp_done = dn; v.exp_stall = sc;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic check_all_zero(string name);
      logic [31:0] agg;
      agg = {16'd0, o_pe_en, o_in_ready, o_w_load, o_out_valid, o_busy, o_done, o_err,
             1'b0, o_pe_in_data} | {30'd0, o_w_addr};
      check(name, agg, 32'd0);
   endtask

   task automatic run_vec(vec_t v);
      int load_n = 0, stream_n = 0, drain_n = 0, ov_n = 0, err_n = 0;
      int done_n = 0, done_c = 0, busy_n = 0, stalled = 0, xfers = 0;
      int pend = 0, pend_val = 0, idle_bad = 0, budget;
      budget = (v.exp_err != 0) ? 20 : 600;
      @(negedge clk);
      vec_len = LW'(v.len);
      start = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (v.hold_start == 0) start = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         in_valid = !(xfers == v.stall_at && stalled < v.stall_len);
         in_data  = EB'(30 + xfers);
         #1;
         if (pend != 0) begin
            check("pe_in_data", o_pe_in_data, pend_val);
            pend = 0;
         end
         if (o_busy) busy_n++;
         if (o_err) err_n++;
         if (o_out_valid) ov_n++;
         if (o_in_ready && !in_valid) stalled++;
         if (o_pe_en) begin
            if (o_w_load) begin
               check("w_addr", o_w_addr, load_n);
               load_n++;
            end else if (o_in_ready) begin
               stream_n++;
               pend = 1;
               pend_val = 30 + xfers;
               xfers++;
            end else begin
               drain_n++;
               pend = 1;
               pend_val = 0;
            end
         end
         if (o_done) begin
            done_n++;
            done_c = c;
            start = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("err_pulses", err_n, v.exp_err);
      check("load_pe_en", load_n, v.exp_load);
      check("stream_pe_en", stream_n, v.exp_stream);
      check("drain_pe_en", drain_n, v.exp_drain);
      check("out_valid_cnt", ov_n, v.exp_ov);
      check("done_cycle", done_c, v.exp_done);
      check("done_count", done_n, (v.exp_err != 0) ? 0 : 1);
      if (v.exp_err != 0) check("busy_on_err", busy_n, 0);
`ifdef PE_CTRL_STALL_CNT_EN
      if (v.exp_err == 0) check("stall_cnt", o_stall_cnt, v.exp_stall);
`endif
      repeat (3) begin
         @(posedge clk); #2;
         if (o_busy || o_done || o_pe_en || o_in_ready) idle_bad++;
      end
      check("idle_after_job", idle_bad, 0);
   endtask

   initial begin
      int drain_seen, found;
      vecs[0] = mk(6,  0, -1, 0, 0, 4,  6, 3,  6,  66, 0);
      vecs[1] = mk(3,  0, -1, 0, 1, 0,  0, 0,  0,   0, 0);
      vecs[2] = mk(65, 0, -1, 0, 1, 0,  0, 0,  0,   0, 0);
      vecs[3] = mk(4,  0,  1, 7, 0, 4,  4, 3,  4,  63, 7);
      vecs[4] = mk(4,  1, -1, 0, 0, 4,  4, 3,  4,  56, 0);
      vecs[5] = mk(64, 0, -1, 0, 0, 4, 64, 3, 64, 356, 0);
      vecs[6] = mk(0,  0, -1, 0, 1, 0,  0, 0,  0,   0, 0);
      vecs[7] = mk(5,  0,  0, 3, 0, 4,  5, 3,  5,  64, 3);

      rst_n = 1'b0;
      start = 1'b1;
      vec_len = LW'(6);
      repeat (3) @(posedge clk);
      #2;
      check_all_zero("reset_outputs");
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // reset asserted while the second DRAIN step is on the array
      @(negedge clk);
      vec_len = LW'(6);
      start = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      drain_seen = 0;
      found = 0;
      for (int c = 1; c <= 200; c++) begin
         #1;
         if (o_pe_en && !o_w_load && !o_in_ready) drain_seen++;
         if (drain_seen == 2) begin
            found = 1;
            break;
         end
         @(posedge clk); #1;
      end
      check("second_drain_reached", found, 1);
      check("busy_before_reset", o_busy, 1);
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset_outputs");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(mk(4, 0, -1, 0, 0, 4, 4, 3, 4, 56, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pe_array_ctrl.md
PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 Parameter ELEMENT_BITS, default 8, element width in bits.
REQ-002 Parameter P, default 4, number of PE columns in the array.
REQ-003 Parameter CLK_RATIO, default 5, sys_clk cycles per PE step; legal range 2..16.
REQ-004 Parameter MAX_LEN, default 64, maximum input vector length.
REQ-005 sys_clk  in  1  single clock, rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  job request; sampled in IDLE only.
REQ-008 vec_len  in  $clog2(MAX_LEN+1)  input elements per job; sampled with start.
REQ-009 in_valid  in  1  upstream input element valid.
REQ-010 in_data  in  ELEMENT_BITS  upstream input element.
REQ-011 in_ready  out  1  controller accepts in_data this cycle.
REQ-012 pe_en  out  1  one-cycle PE step strobe; the array advances on it.
REQ-013 w_load  out  1  weight-load phase; the array latches weight_data_in on pe_en.
REQ-014 w_addr  out  $clog2(P)  weight row being loaded.
REQ-015 pe_in_data  out  ELEMENT_BITS  element driven to the array's input_data_in.
REQ-016 out_valid  out  1  array output_data_out is valid on this pe_en.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 done  out  1  one-cycle pulse at job end.
REQ-019 err  out  1  one-cycle pulse on an illegal vec_len.

Function
REQ-020 FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
REQ-021 IDLE->LOAD_W on start with P <= vec_len <= MAX_LEN; otherwise start pulses err and the FSM stays in IDLE.
REQ-022 Prescaler: counts 0..CLK_RATIO-1 while busy, restarts at 0 on leaving IDLE, and produces tick when the count equals CLK_RATIO-1.
REQ-023 LOAD_W: pe_en=tick, w_load=1, and w_addr increments 0..P-1 per step; after P steps the FSM goes to STREAM.
REQ-024 STREAM: in_ready=tick. pe_en=tick&&in_valid. pe_in_data=in_data registered on the transfer.
REQ-025 STREAM stall: on tick with in_valid=0, the prescaler holds at CLK_RATIO-1 until in_valid; no pe_en is issued while stalled.
REQ-026 After vec_len transfers, STREAM goes to DRAIN.
REQ-027 DRAIN: P-1 steps with pe_en=tick and pe_in_data=0, then DONE.
REQ-028 out_valid=pe_en on STREAM steps with index >= P-1 (0-based) and on all DRAIN steps; exactly vec_len out_valid pulses are issued per job.
REQ-029 DONE: done=1 for one cycle, then IDLE.
REQ-030 start while busy is ignored; no queuing.
REQ-031 vec_len=P is the boundary case: one out_valid during STREAM, then P-1 during DRAIN.
REQ-032 in_ready is never asserted outside STREAM.

Reset
REQ-033 reset_n low, at any time including mid-job, forces IDLE, clears all counters, and drives every output to 0 asynchronously.
REQ-034 After reset release, the first start is honoured on the next rising edge.

Configuration
REQ-035 Macro PE_CTRL_STALL_CNT_EN, when defined, adds output stall_cnt (16 bits): it counts stalled sys_clk cycles in STREAM, saturates at 0xFFFF, and clears on job start.
REQ-036 Without PE_CTRL_STALL_CNT_EN, the stall_cnt port and its logic are absent; all other behaviour is identical.

Structure
REQ-037 Package pe_ctrl_pkg holds the state enum (IDLE, LOAD_W, STREAM, DRAIN, DONE) and default parameter constants.
REQ-038 Sub-module pe_tick_gen implements the prescaler with inputs run, hold, and clear, and output tick.
REQ-039 The FSM, step counters, and data register reside in pe_array_ctrl.

Verification
REQ-040 Reset then start with vec_len=6, in_valid=1 constant -> 4 LOAD_W pe_en with w_addr 0,1,2,3; 6 STREAM pe_en; 3 DRAIN pe_en; 6 out_valid pulses; done on cycle 5*13+1 after start.
REQ-041 vec_len=3 and vec_len=65 -> err pulse, busy stays 0, no pe_en.
REQ-042 vec_len=4, in_valid low for 7 cycles at the 2nd STREAM tick -> pe_en delayed 7 cycles, data order preserved, stall_cnt=7 when the macro is defined.
REQ-043 start held during STREAM -> ignored; the job completes once and returns to IDLE with exactly one done.
REQ-044 reset_n low at the 2nd DRAIN step -> all outputs 0 immediately; a new start with vec_len=4 completes normally.
REQ-045 Streamed values 30..35 appear on pe_in_data in order, each registered on its STREAM pe_en; all DRAIN pe_in_data values are 0.
